// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider.
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high; valid/ready must not depend combinationally on each other,
// and a producer holds its payload stable while valid is high and ready is low.
interface div_unit_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_a;
  logic [31:0] io_b;
  logic [1:0]  io_op;
  logic        io_kill;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_res;

  modport master (
    output io_in_valid, io_a, io_b, io_op, io_kill, io_out_ready,
    input  io_in_ready, io_out_valid, io_res
  );

  modport slave (
    input  io_in_valid, io_a, io_b, io_op, io_kill, io_out_ready,
    output io_in_ready, io_out_valid, io_res
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider/remainder unit for the RV32M divide group.
// One quotient bit per cycle; divide-by-zero and signed overflow are resolved
// at accept time and skip the iteration loop entirely.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  io,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   res_q;
  logic [5:0]        cnt_q;

  // Accept-time decode of the incoming request
  logic            fire;
  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] fast_res;

  // Single restoring iteration plus the final sign fixup
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  assign fire = io.io_in_valid & (state_q == IDLE) & ~io.io_kill;

  // Decode operands: absolute values for signed ops, raw values otherwise
  always_comb begin
    is_signed = ~io.io_op[0];
    is_rem    = io.io_op[1];
    a_neg     = is_signed & io.io_a[XLEN-1];
    b_neg     = is_signed & io.io_b[XLEN-1];
    abs_a     = a_neg ? (~io.io_a + 1'b1) : io.io_a;
    abs_b     = b_neg ? (~io.io_b + 1'b1) : io.io_b;
    div_zero  = (io.io_b == '0);
    sgn_ovf   = is_signed & (io.io_a == {1'b1, {(XLEN-1){1'b0}}}) & (io.io_b == '1);
    fast_res  = '0;
    if (div_zero) begin
      fast_res = is_rem ? io.io_a : '1;
    end else if (sgn_ovf) begin
      fast_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One shift/compare/subtract step; diff's top bit flags shifted < divisor
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = ~diff[XLEN];
    rem_n     = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n     = {quo_q[XLEN-2:0], ge};
    quo_fix   = neg_quo_q ? (~quo_n + 1'b1) : quo_n;
    rem_fix   = neg_rem_q ? (~rem_n + 1'b1) : rem_n;
    final_res = op_q[1] ? rem_fix : quo_fix;
  end

  // Control FSM and datapath registers; kill overrides every other event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else if (io.io_kill) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            op_q      <= io.io_op;
            neg_quo_q <= ~is_rem & (a_neg ^ b_neg);
            neg_rem_q <= is_rem & a_neg;
            rem_q     <= '0;
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            cnt_q     <= '0;
            if (div_zero || sgn_ovf) begin
              res_q   <= fast_res;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(XLEN - 1)) begin
            res_q   <= final_res;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (io.io_out_ready) begin
            res_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          res_q   <= '0;
        end
      endcase
    end
  end

  assign io.io_in_ready  = (state_q == IDLE);
  assign io.io_out_valid = (state_q == DONE);
  assign io.io_res       = res_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reset, normal and fast paths, signed fixups,
// backpressure, kill and mid-operation reset.
module tb_div_unit;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  int vectors;
  int miscompares;
  int lat;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit_if dif();

  div_unit #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .io          (dif),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle, then scramble the operand bus
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    dif.io_in_valid = 1'b1;
    dif.io_op       = op;
    dif.io_a        = a;
    dif.io_b        = b;
    step();
    dif.io_in_valid = 1'b0;
    dif.io_a        = $urandom;
    dif.io_b        = $urandom;
    dif.io_op       = 2'($urandom_range(0, 3));
  endtask

  // Count cycles after accept until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!dif.io_out_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    issue(op, a, b);
    if (exp_lat != 0) begin
      check({tag, "_calc_state"}, 32'(dbg_state), 32'd1);
      check({tag, "_calc_res0"}, dif.io_res, 32'h0);
    end
    wait_valid(n);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, dif.io_res, exp);
    check({tag, "_inrdy_busy"}, 32'(dif.io_in_ready), 32'd0);
    dif.io_out_ready = 1'b1;
    step();
    dif.io_out_ready = 1'b0;
    check({tag, "_outvld_after"}, 32'(dif.io_out_valid), 32'd0);
    check({tag, "_inrdy_after"}, 32'(dif.io_in_ready), 32'd1);
    check({tag, "_res_after"}, dif.io_res, 32'h0);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b0;
    dif.io_in_valid  = 1'b0;
    dif.io_a         = '0;
    dif.io_b         = '0;
    dif.io_op        = '0;
    dif.io_kill      = 1'b0;
    dif.io_out_ready = 1'b0;

    #2;
    check("rst_inrdy", 32'(dif.io_in_ready), 32'd1);
    check("rst_outvld", 32'(dif.io_out_valid), 32'd0);
    check("rst_res", dif.io_res, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Normal path, unsigned and signed
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 32);
    run_op("divu_7_100", OP_DIVU, 32'd7, 32'd100, 32'd0, 32);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
    run_op("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);
    run_op("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);

    // Fast paths
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

    // Backpressure: result held for 10 cycles
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd32);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_vld", 32'(dif.io_out_valid), 32'd1);
      check("bp_hold_res", dif.io_res, 32'hFFFF_FFFF);
      check("bp_hold_inrdy", 32'(dif.io_in_ready), 32'd0);
      step();
    end
    check("bp_last_res", dif.io_res, 32'hFFFF_FFFF);
    dif.io_out_ready = 1'b1;
    step();
    dif.io_out_ready = 1'b0;
    check("bp_inrdy_after", 32'(dif.io_in_ready), 32'd1);
    check("bp_outvld_after", 32'(dif.io_out_valid), 32'd0);

    // Kill mid-CALC at T+10, new request at T+11
    issue(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    check("kill_pre_state", 32'(dbg_state), 32'd1);
    dif.io_kill = 1'b1;
    step();
    dif.io_kill = 1'b0;
    check("kill_state", 32'(dbg_state), 32'd0);
    check("kill_outvld", 32'(dif.io_out_valid), 32'd0);
    check("kill_inrdy", 32'(dif.io_in_ready), 32'd1);
    run_op("post_kill_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32);

    // Request alongside kill in IDLE is dropped
    dif.io_in_valid = 1'b1;
    dif.io_op       = OP_DIVU;
    dif.io_a        = 32'd9;
    dif.io_b        = 32'd0;
    dif.io_kill     = 1'b1;
    step();
    dif.io_in_valid = 1'b0;
    dif.io_kill     = 1'b0;
    check("kill_idle_state", 32'(dbg_state), 32'd0);
    check("kill_idle_outvld", 32'(dif.io_out_valid), 32'd0);

    // Kill together with out_ready in DONE discards the result
    issue(OP_DIV, 32'd5, 32'd0);
    check("kdone_vld", 32'(dif.io_out_valid), 32'd1);
    dif.io_kill      = 1'b1;
    dif.io_out_ready = 1'b1;
    step();
    dif.io_kill      = 1'b0;
    dif.io_out_ready = 1'b0;
    check("kdone_state", 32'(dbg_state), 32'd0);
    check("kdone_outvld", 32'(dif.io_out_valid), 32'd0);
    check("kdone_res", dif.io_res, 32'h0);

    // Async reset mid-CALC at T+20
    issue(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 19; i++) step();
    check("arst_pre_state", 32'(dbg_state), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_outvld", 32'(dif.io_out_valid), 32'd0);
    check("arst_inrdy", 32'(dif.io_in_ready), 32'd1);
    check("arst_res", dif.io_res, 32'h0);
    check("arst_state", 32'(dbg_state), 32'd0);
    step();
    reset = 1'b1;
    run_op("post_rst_divu_0_0", OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
